// File: rtl/rc4_pkg.sv
// ---------------------------------------------------------------------------
// rc4_pkg -- shared definitions for the RC4 decrypt sequencer.
//
// Contents:
//   MSG_LEN_DEF  default number of ciphertext bytes per run
//   S_AW         S RAM address width (256-entry permutation)
//   MSG_AW       ciphertext ROM / plaintext RAM address width
//   rc4_state_e  sequencer state encoding, one state per clock cycle
// ---------------------------------------------------------------------------
package rc4_pkg;

   localparam int MSG_LEN_DEF = 32;
   localparam int S_AW        = 8;
   localparam int MSG_AW      = 5;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_INC_I   = 4'd1,
      ST_RD_SI   = 4'd2,
      ST_WAIT_SI = 4'd3,
      ST_GET_SI  = 4'd4,
      ST_RD_SJ   = 4'd5,
      ST_WAIT_SJ = 4'd6,
      ST_GET_SJ  = 4'd7,
      ST_WR_SI   = 4'd8,
      ST_WR_SJ   = 4'd9,
      ST_RD_F    = 4'd10,
      ST_WAIT_F  = 4'd11,
      ST_GET_F   = 4'd12,
      ST_WR_OUT  = 4'd13,
      ST_DONE    = 4'd14
   } rc4_state_e;

endpackage

// File: rtl/rc4_decrypt_fsm.sv
// ---------------------------------------------------------------------------
// rc4_decrypt_fsm -- RC4 PRGA sequencer that decrypts MSG_LEN ciphertext bytes
// using an externally held S permutation RAM.
//
// Every memory has a registered address plus a registered read port: an
// address driven in cycle N yields data that is sampled in cycle N+2, so each
// read is RD (drive address), WAIT (hold address), GET (capture data).
//
// Ports:
//   clk        single clock
//   reset      synchronous, active-high
//   start      run request (level); honoured only in IDLE and DONE
//   done       high in DONE until start is seen low
//   busy       high whenever the block owns the S RAM (all but IDLE/DONE)
//   s_addr     S RAM address        s_wdata  S RAM write data
//   s_wren     S RAM write enable   s_rdata  S RAM read data
//   rom_addr   ciphertext ROM addr  rom_rdata ciphertext byte
//   out_addr   plaintext RAM addr   out_wdata plaintext byte
//   out_wren   plaintext RAM write enable
//
// Handshake: start is a level. In IDLE the first edge with start=1 launches a
// run; in DONE done stays high until an edge samples start=0. Elsewhere start
// is ignored. All unused addresses/write data are held at 0.
// ---------------------------------------------------------------------------
module rc4_decrypt_fsm
   import rc4_pkg::*;
#(
   parameter int MSG_LEN = MSG_LEN_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              done,
   output logic              busy,
   output logic [S_AW-1:0]   s_addr,
   output logic [7:0]        s_wdata,
   output logic              s_wren,
   input  logic [7:0]        s_rdata,
   output logic [MSG_AW-1:0] rom_addr,
   input  logic [7:0]        rom_rdata,
   output logic [MSG_AW-1:0] out_addr,
   output logic [7:0]        out_wdata,
   output logic              out_wren
);

   localparam logic [MSG_AW-1:0] LAST_K = MSG_AW'(MSG_LEN - 1);

   rc4_state_e        state_q, state_d;
   logic [S_AW-1:0]   i_q, i_d;
   logic [S_AW-1:0]   j_q, j_d;
   logic [MSG_AW-1:0] k_q, k_d;
   logic [7:0]        si_q, si_d;
   logic [7:0]        sj_q, sj_d;
   logic [7:0]        f_q, f_d;
   logic [7:0]        c_q, c_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         si_q    <= '0;
         sj_q    <= '0;
         f_q     <= '0;
         c_q     <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
         f_q     <= f_d;
         c_q     <= c_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      j_d       = j_q;
      k_d       = k_q;
      si_d      = si_q;
      sj_d      = sj_q;
      f_d       = f_q;
      c_d       = c_q;
      done      = 1'b0;
      busy      = 1'b1;
      s_addr    = '0;
      s_wdata   = '0;
      s_wren    = 1'b0;
      rom_addr  = '0;
      out_addr  = '0;
      out_wdata = '0;
      out_wren  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
               state_d = ST_INC_I;
            end
         end
         ST_INC_I: begin
            i_d     = i_q + 8'd1;
            state_d = ST_RD_SI;
         end
         ST_RD_SI: begin
            s_addr  = i_q;
            state_d = ST_WAIT_SI;
         end
         ST_WAIT_SI: begin
            s_addr  = i_q;
            state_d = ST_GET_SI;
         end
         ST_GET_SI: begin
            si_d    = s_rdata;
            j_d     = j_q + s_rdata;
            state_d = ST_RD_SJ;
         end
         ST_RD_SJ: begin
            s_addr  = j_q;
            state_d = ST_WAIT_SJ;
         end
         ST_WAIT_SJ: begin
            s_addr  = j_q;
            state_d = ST_GET_SJ;
         end
         ST_GET_SJ: begin
            sj_d    = s_rdata;
            state_d = ST_WR_SI;
         end
         // When i==j both writes land on the same word with the same value.
         ST_WR_SI: begin
            s_addr  = i_q;
            s_wdata = sj_q;
            s_wren  = 1'b1;
            state_d = ST_WR_SJ;
         end
         ST_WR_SJ: begin
            s_addr  = j_q;
            s_wdata = si_q;
            s_wren  = 1'b1;
            state_d = ST_RD_F;
         end
         // Issued after both swap writes, so S[si+sj] reflects the swap.
         ST_RD_F: begin
            s_addr   = si_q + sj_q;
            rom_addr = k_q;
            state_d  = ST_WAIT_F;
         end
         ST_WAIT_F: begin
            s_addr   = si_q + sj_q;
            rom_addr = k_q;
            state_d  = ST_GET_F;
         end
         ST_GET_F: begin
            f_d     = s_rdata;
            c_d     = rom_rdata;
            state_d = ST_WR_OUT;
         end
         ST_WR_OUT: begin
            out_addr  = k_q;
            out_wdata = f_q ^ c_q;
            out_wren  = 1'b1;
            if (k_q == LAST_K) begin
               state_d = ST_DONE;
            end else begin
               k_d     = k_q + 5'd1;
               state_d = ST_INC_I;
            end
         end
         ST_DONE: begin
            busy = 1'b0;
            done = 1'b1;
            if (!start) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            busy    = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_rc4_decrypt_fsm.sv
// ---------------------------------------------------------------------------
// tb_rc4_decrypt_fsm -- two DUT copies (MSG_LEN=3 and MSG_LEN=32) each with
// their own S RAM, ciphertext ROM and plaintext RAM models. Memories have a
// registered address and a registered data output (two-cycle read).
// Expected plaintext and final S come from a plain RC4 PRGA loop.
// ---------------------------------------------------------------------------
module tb_rc4_decrypt_fsm;

   localparam int LEN_A = 3;
   localparam int LEN_B = 32;

   logic       clk = 1'b0;
   logic       reset [2];
   logic       start [2];
   logic       done [2];
   logic       busy [2];
   logic [7:0] s_addr [2];
   logic [7:0] s_wdata [2];
   logic       s_wren [2];
   logic [7:0] s_rdata [2];
   logic [4:0] rom_addr [2];
   logic [7:0] rom_rdata [2];
   logic [4:0] out_addr [2];
   logic [7:0] out_wdata [2];
   logic       out_wren [2];

   logic [7:0] s_mem [2][256];
   logic [7:0] s_init [2][256];
   logic       s_load [2];
   logic [7:0] rom_mem [2][32];
   logic [7:0] out_mem [2][32];
   logic [7:0] s_aq [2];
   logic [4:0] rom_aq [2];

   logic [7:0] ref_s [256];
   logic [7:0] ref_out [32];

   int checks = 0;
   int errors = 0;
   int sw_cnt [2] = '{0, 0};
   int ow_cnt [2] = '{0, 0};
   int both_cnt [2] = '{0, 0};
   int zv_cnt [2] = '{0, 0};

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      rc4_decrypt_fsm #(.MSG_LEN(g == 0 ? LEN_A : LEN_B)) u_dut (
         .clk       (clk),
         .reset     (reset[g]),
         .start     (start[g]),
         .done      (done[g]),
         .busy      (busy[g]),
         .s_addr    (s_addr[g]),
         .s_wdata   (s_wdata[g]),
         .s_wren    (s_wren[g]),
         .s_rdata   (s_rdata[g]),
         .rom_addr  (rom_addr[g]),
         .rom_rdata (rom_rdata[g]),
         .out_addr  (out_addr[g]),
         .out_wdata (out_wdata[g]),
         .out_wren  (out_wren[g])
      );
   end

   // Memory models: registered address, registered read data.
   always @(posedge clk) begin
      for (int u = 0; u < 2; u++) begin
         s_aq[u]      <= s_addr[u];
         s_rdata[u]   <= s_mem[u][s_aq[u]];
         rom_aq[u]    <= rom_addr[u];
         rom_rdata[u] <= rom_mem[u][rom_aq[u]];
         if (s_load[u]) begin
            for (int x = 0; x < 256; x++) s_mem[u][x] <= s_init[u][x];
         end else if (s_wren[u]) begin
            s_mem[u][s_addr[u]] <= s_wdata[u];
         end
         if (out_wren[u]) out_mem[u][out_addr[u]] <= out_wdata[u];
      end
   end

   // Write-strobe and idle-bus monitor.
   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (s_wren[u]) sw_cnt[u]++;
         if (out_wren[u]) ow_cnt[u]++;
         if (s_wren[u] && out_wren[u]) both_cnt[u]++;
         if ((!s_wren[u] && s_wdata[u] != 8'd0) ||
             (!out_wren[u] && (out_wdata[u] != 8'd0 || out_addr[u] != 5'd0)))
            zv_cnt[u]++;
      end
   end

   function automatic logic [37:0] out_vec(input int u);
      return {done[u], busy[u], s_wren[u], out_wren[u], s_addr[u], s_wdata[u],
              rom_addr[u], out_addr[u], out_wdata[u]};
   endfunction

   // ---- driver tasks -------------------------------------------------------
   task automatic load_s(input int u);
      s_load[u] = 1'b1;
      @(posedge clk); #1;
      s_load[u] = 1'b0;
   endtask

   task automatic fill_random(input int u);
      for (int x = 0; x < 256; x++) s_init[u][x] = 8'($urandom_range(0, 255));
      for (int x = 0; x < 32; x++) rom_mem[u][x] = 8'($urandom_range(0, 255));
   endtask

   // Reference RC4 PRGA over the current contents of the bench S RAM.
   task automatic ref_prga(input int u, input int len);
      logic [7:0] i, j, si, sj, t;
      for (int x = 0; x < 256; x++) ref_s[x] = s_mem[u][x];
      i = 8'd0;
      j = 8'd0;
      for (int k = 0; k < len; k++) begin
         i = i + 8'd1;
         si = ref_s[i];
         j = j + si;
         sj = ref_s[j];
         ref_s[i] = sj;
         ref_s[j] = si;
         t = si + sj;
         ref_out[k] = ref_s[t] ^ rom_mem[u][k];
      end
   endtask

   // Pulse start, return cycles from the sampling edge to done (bounded),
   // then let the DUT fall back to IDLE.
   task automatic run_dut(input int u, input int len, output int cyc);
      start[u] = 1'b1;
      @(posedge clk); #1;
      start[u] = 1'b0;
      cyc = 0;
      while (done[u] !== 1'b1 && cyc < 13 * len + 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      @(posedge clk); #1;
   endtask

   // ---- scenario tasks -----------------------------------------------------
   task automatic test_reset();
      reset[0] = 1'b1; reset[1] = 1'b1;
      start[0] = 1'b0; start[1] = 1'b0;
      s_load[0] = 1'b0; s_load[1] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
         checks++;
         if (out_vec(u) !== 38'd0) begin
            errors++;
            $display("FAIL reset_outputs[%0d]: got %h expected 0", u, out_vec(u));
         end
      end
      reset[0] = 1'b0; reset[1] = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_identity();
      int cyc, sw0, ow0, bo0, zv0;
      logic [7:0] exp_b [3];
      exp_b = '{8'h02, 8'h05, 8'h07};
      for (int x = 0; x < 256; x++) s_init[0][x] = 8'(x);
      for (int x = 0; x < 32; x++) rom_mem[0][x] = 8'h00;
      load_s(0);
      sw0 = sw_cnt[0]; ow0 = ow_cnt[0]; bo0 = both_cnt[0]; zv0 = zv_cnt[0];
      run_dut(0, LEN_A, cyc);
      checks++;
      if (cyc !== 13 * LEN_A) begin
         errors++;
         $display("FAIL identity_latency: got %0d expected %0d", cyc, 13 * LEN_A);
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (out_mem[0][k] !== exp_b[k]) begin
            errors++;
            $display("FAIL identity_out[%0d]: got %h expected %h", k, out_mem[0][k], exp_b[k]);
         end
      end
      checks++;
      if ({s_mem[0][2], s_mem[0][3], s_mem[0][5]} !== {8'h03, 8'h05, 8'h02}) begin
         errors++;
         $display("FAIL identity_s: got %h %h %h expected 03 05 02",
                  s_mem[0][2], s_mem[0][3], s_mem[0][5]);
      end
      checks++;
      if ({sw_cnt[0] - sw0, ow_cnt[0] - ow0, both_cnt[0] - bo0, zv_cnt[0] - zv0} !==
          {2 * LEN_A, LEN_A, 0, 0}) begin
         errors++;
         $display("FAIL identity_wren: got sw=%0d ow=%0d both=%0d idle=%0d expected %0d %0d 0 0",
                  sw_cnt[0] - sw0, ow_cnt[0] - ow0, both_cnt[0] - bo0, zv_cnt[0] - zv0,
                  2 * LEN_A, LEN_A);
      end
   endtask

   task automatic test_wrap_ij();
      int cyc, mism, sw0, ow0;
      for (int x = 0; x < 256; x++) s_init[0][x] = 8'(x);
      s_init[0][1] = 8'hFF; s_init[0][255] = 8'h01;
      s_init[0][2] = 8'h03; s_init[0][3] = 8'h02;
      for (int x = 0; x < 32; x++) rom_mem[0][x] = 8'($urandom_range(0, 255));
      rom_mem[0][1] = 8'h0F;
      load_s(0);
      ref_prga(0, LEN_A);
      sw0 = sw_cnt[0]; ow0 = ow_cnt[0];
      run_dut(0, LEN_A, cyc);
      checks++;
      if (out_mem[0][0] !== rom_mem[0][0]) begin
         errors++;
         $display("FAIL wrap_byte0: got %h expected %h", out_mem[0][0], rom_mem[0][0]);
      end
      checks++;
      if (out_mem[0][1] !== 8'h09) begin
         errors++;
         $display("FAIL wrap_byte1_ieqj: got %h expected 09", out_mem[0][1]);
      end
      checks++;
      if (out_mem[0][2] !== ref_out[2]) begin
         errors++;
         $display("FAIL wrap_byte2: got %h expected %h", out_mem[0][2], ref_out[2]);
      end
      checks++;
      if (s_mem[0][2] !== 8'h03) begin
         errors++;
         $display("FAIL wrap_s2: got %h expected 03", s_mem[0][2]);
      end
      mism = 0;
      for (int x = 0; x < 256; x++) if (s_mem[0][x] !== ref_s[x]) mism++;
      checks++;
      if (mism !== 0) begin
         errors++;
         $display("FAIL wrap_final_s: got %0d differing entries expected 0", mism);
      end
      checks++;
      if ({sw_cnt[0] - sw0, ow_cnt[0] - ow0} !== {2 * LEN_A, LEN_A}) begin
         errors++;
         $display("FAIL wrap_wren: got sw=%0d ow=%0d expected %0d %0d",
                  sw_cnt[0] - sw0, ow_cnt[0] - ow0, 2 * LEN_A, LEN_A);
      end
   endtask

   task automatic test_latency();
      int cyc, busy_bad, done_bad, sw0, ow0, bo0, zv0, mism;
      fill_random(1);
      load_s(1);
      ref_prga(1, LEN_B);
      sw0 = sw_cnt[1]; ow0 = ow_cnt[1]; bo0 = both_cnt[1]; zv0 = zv_cnt[1];
      start[1] = 1'b1;
      @(posedge clk); #1;
      cyc = 0;
      busy_bad = 0;
      while (done[1] !== 1'b1 && cyc < 13 * LEN_B + 50) begin
         if (busy[1] !== 1'b1) busy_bad++;
         @(posedge clk); #1;
         cyc++;
      end
      checks++;
      if (cyc !== 13 * LEN_B) begin
         errors++;
         $display("FAIL latency_done: got %0d expected %0d", cyc, 13 * LEN_B);
      end
      checks++;
      if (busy_bad !== 0 || busy[1] !== 1'b0) begin
         errors++;
         $display("FAIL latency_busy: got %0d low cycles, busy_at_done=%b expected 0 and 0",
                  busy_bad, busy[1]);
      end
      done_bad = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (done[1] !== 1'b1) done_bad++;
      end
      checks++;
      if (done_bad !== 0) begin
         errors++;
         $display("FAIL latency_done_hold: got %0d low cycles expected 0", done_bad);
      end
      start[1] = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({done[1], busy[1]} !== 2'b00) begin
         errors++;
         $display("FAIL latency_release: got done/busy %b%b expected 00", done[1], busy[1]);
      end
      mism = 0;
      for (int k = 0; k < LEN_B; k++) if (out_mem[1][k] !== ref_out[k]) mism++;
      checks++;
      if (mism !== 0) begin
         errors++;
         $display("FAIL latency_plaintext: got %0d wrong bytes expected 0", mism);
      end
      checks++;
      if ({sw_cnt[1] - sw0, ow_cnt[1] - ow0, both_cnt[1] - bo0, zv_cnt[1] - zv0} !==
          {2 * LEN_B, LEN_B, 0, 0}) begin
         errors++;
         $display("FAIL latency_wren: got sw=%0d ow=%0d both=%0d idle=%0d expected %0d %0d 0 0",
                  sw_cnt[1] - sw0, ow_cnt[1] - ow0, both_cnt[1] - bo0, zv_cnt[1] - zv0,
                  2 * LEN_B, LEN_B);
      end
   endtask

   task automatic test_reset_midrun();
      int cyc, mism, sw0, ow0, bo0;
      fill_random(1);
      load_s(1);
      start[1] = 1'b1;
      @(posedge clk); #1;
      start[1] = 1'b0;
      repeat (99) @(posedge clk);
      #1;
      reset[1] = 1'b1;
      @(posedge clk); #1;
      reset[1] = 1'b0;
      checks++;
      if (out_vec(1) !== 38'd0) begin
         errors++;
         $display("FAIL midrun_reset_outputs: got %h expected 0", out_vec(1));
      end
      // Restart on the partially swapped S left behind by the aborted run.
      ref_prga(1, LEN_B);
      sw0 = sw_cnt[1]; ow0 = ow_cnt[1]; bo0 = both_cnt[1];
      run_dut(1, LEN_B, cyc);
      checks++;
      if (cyc !== 13 * LEN_B) begin
         errors++;
         $display("FAIL midrun_restart_latency: got %0d expected %0d", cyc, 13 * LEN_B);
      end
      mism = 0;
      for (int k = 0; k < LEN_B; k++) if (out_mem[1][k] !== ref_out[k]) mism++;
      for (int x = 0; x < 256; x++) if (s_mem[1][x] !== ref_s[x]) mism++;
      checks++;
      if (mism !== 0) begin
         errors++;
         $display("FAIL midrun_restart_data: got %0d mismatches expected 0", mism);
      end
      checks++;
      if ({sw_cnt[1] - sw0, ow_cnt[1] - ow0, both_cnt[1] - bo0} !== {2 * LEN_B, LEN_B, 0}) begin
         errors++;
         $display("FAIL midrun_wren: got sw=%0d ow=%0d both=%0d expected %0d %0d 0",
                  sw_cnt[1] - sw0, ow_cnt[1] - ow0, both_cnt[1] - bo0, 2 * LEN_B, LEN_B);
      end
   endtask

   task automatic test_handshake();
      int cyc, mism, done_bad;
      fill_random(0);
      load_s(0);
      ref_prga(0, LEN_A);
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      cyc = 0;
      while (done[0] !== 1'b1 && cyc < 13 * LEN_A + 50) begin
         start[0] = (cyc == 10) ? 1'b1 : 1'b0;
         @(posedge clk); #1;
         cyc++;
      end
      checks++;
      if (cyc !== 13 * LEN_A) begin
         errors++;
         $display("FAIL handshake_latency: got %0d expected %0d", cyc, 13 * LEN_A);
      end
      start[0] = 1'b1;
      done_bad = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done[0] !== 1'b1) done_bad++;
      end
      checks++;
      if (done_bad !== 0) begin
         errors++;
         $display("FAIL handshake_done_hold: got %0d low cycles expected 0", done_bad);
      end
      start[0] = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({done[0], busy[0]} !== 2'b00) begin
         errors++;
         $display("FAIL handshake_idle: got done/busy %b%b expected 00", done[0], busy[0]);
      end
      mism = 0;
      for (int k = 0; k < LEN_A; k++) if (out_mem[0][k] !== ref_out[k]) mism++;
      for (int x = 0; x < 256; x++) if (s_mem[0][x] !== ref_s[x]) mism++;
      checks++;
      if (mism !== 0) begin
         errors++;
         $display("FAIL handshake_data: got %0d mismatches expected 0", mism);
      end
   endtask

   task automatic test_back_to_back();
      int cyc, mism, sw0, ow0, bo0;
      for (int r = 0; r < 4; r++) begin
         fill_random(0);
         load_s(0);
         ref_prga(0, LEN_A);
         sw0 = sw_cnt[0]; ow0 = ow_cnt[0]; bo0 = both_cnt[0];
         run_dut(0, LEN_A, cyc);
         mism = 0;
         for (int k = 0; k < LEN_A; k++) if (out_mem[0][k] !== ref_out[k]) mism++;
         for (int x = 0; x < 256; x++) if (s_mem[0][x] !== ref_s[x]) mism++;
         checks++;
         if (mism !== 0 || cyc !== 13 * LEN_A) begin
            errors++;
            $display("FAIL b2b_run%0d: got %0d mismatches, latency %0d expected 0, %0d",
                     r, mism, cyc, 13 * LEN_A);
         end
         checks++;
         if ({sw_cnt[0] - sw0, ow_cnt[0] - ow0, both_cnt[0] - bo0} !== {2 * LEN_A, LEN_A, 0}) begin
            errors++;
            $display("FAIL b2b_wren%0d: got sw=%0d ow=%0d both=%0d expected %0d %0d 0",
                     r, sw_cnt[0] - sw0, ow_cnt[0] - ow0, both_cnt[0] - bo0, 2 * LEN_A, LEN_A);
         end
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_wrap_ij();
      test_latency();
      test_reset_midrun();
      test_handshake();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rc4_decrypt_fsm.md
RC4_DECRYPT_FSM -- requirements
Module: rc4_decrypt_fsm

Interface
REQ-001 SHALL have parameter: MSG_LEN, 32, number of ciphertext bytes processed per run (1..32).
REQ-002 SHALL have these ports, with clock and reset listed first:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- start  in  1  run request, level.
- done  out  1  run complete.
- busy  out  1  block owns the S RAM; drives the top-level RAM mux select.
- s_addr  out  8  S RAM address.
- s_wdata  out  8  S RAM write data.
- s_wren  out  1  S RAM write enable.
- s_rdata  in  8  S RAM read data.
- rom_addr  out  5  ciphertext ROM address.
- rom_rdata  in  8  ciphertext byte.
- out_addr  out  5  plaintext RAM address.
- out_wdata  out  8  plaintext byte.
- out_wren  out  1  plaintext RAM write enable.
REQ-003 SHALL use one clock domain and a synchronous active-high reset; there are no other clocks or resets.

Function
REQ-004 SHALL treat all memories as having a registered address: read data for an address driven in cycle N is sampled in cycle N+2, after a single wait state.
REQ-005 SHALL run the RC4 PRGA. The per-run initial values are i=0, j=0, k=0. For each byte k:
- i=i+1
- si=S[i]
- j=j+si
- sj=S[j]
- S[i]=sj
- S[j]=si
- f=S[si+sj]
- out[k]=f XOR rom[k]
REQ-006 SHALL compute all of i, j, si+sj and k as unsigned modulo 2^width with no carry out: 8 bits for i, j and si+sj, 5 bits for k.
REQ-007 SHALL step through these states, one cycle each:
- IDLE
- INC_I
- RD_SI (s_addr=i)
- WAIT_SI (s_addr=i)
- GET_SI (si<=s_rdata, j<=j+s_rdata)
- RD_SJ (s_addr=j)
- WAIT_SJ (s_addr=j)
- GET_SJ (sj<=s_rdata)
- WR_SI (s_addr=i, s_wdata=sj, s_wren=1)
- WR_SJ (s_addr=j, s_wdata=si, s_wren=1)
- RD_F (s_addr=si+sj, rom_addr=k)
- WAIT_F (both addresses held)
- GET_F (f<=s_rdata, c<=rom_rdata)
- WR_OUT (out_addr=k, out_wdata=f^c, out_wren=1)
- DONE
REQ-008 SHALL leave WR_OUT for DONE when k==MSG_LEN-1; otherwise it SHALL increment k and go to INC_I.
REQ-009 SHALL leave IDLE for INC_I on the first edge where start=1, clearing i, j and k on that edge.
REQ-010 SHALL hold done=1 in DONE until start=0 is sampled, then go to IDLE; done SHALL be 0 in every other state.
REQ-011 SHALL ignore start while in any state other than IDLE or DONE.
REQ-012 SHALL assert busy in every state except IDLE and DONE.
REQ-013 SHALL make done rise exactly 13*MSG_LEN cycles after the edge that sampled start in IDLE.
REQ-014 SHALL handle i==j with no special path: WR_SJ rewrites the same location with the same value.
REQ-015 SHALL read S[si+sj] after both swap writes, so it returns post-swap contents.
REQ-016 SHALL never assert s_wren and out_wren in the same cycle, and SHALL assert each for exactly one cycle per write.
REQ-017 SHALL drive s_wdata, out_wdata and all addresses to 0 in every state that does not use them.

Reset
REQ-018 SHALL, on reset=1 at any clock edge including mid-run, go to IDLE and drive these outputs on the next cycle:
- done=0, busy=0
- s_wren=0, out_wren=0
- all addresses=0, all write data=0
- i, j, k, si, sj, f, c=0
REQ-019 SHALL NOT restore S RAM or plaintext RAM contents on reset; a run that restarts after a mid-run reset operates on the partially swapped S.

Structure
REQ-020 SHALL place these in shared package rc4_pkg:
- state enum type
- MSG_LEN default (32)
- S address width (8)
- message address width (5)
REQ-021 SHALL be implemented as a single module; no sub-module is warranted because the datapath is a handful of registers and one XOR.

Verification
REQ-022 Bench SHALL model S RAM, ROM and output RAM with the REQ-004 latency and cover these scenarios:
1. Identity swap and keystream: preload S[x]=x, ROM all 0x00, MSG_LEN=3, pulse start. Required: out = 0x02, 0x05, 0x07; afterwards S[2]=0x03, S[3]=0x05, S[5]=0x02.
2. Latency: MSG_LEN=32, start held high. Required: done rises 416 cycles after start is sampled; busy=1 throughout, then 0.
3. j wrap and i==j: preload S identity except S[1]=0xFF, S[0xFF]=0x01, S[2]=0x03, S[3]=0x02, ROM[1]=0x0F. Required: byte0 = S[0]^ROM[0] = 0x00^ROM[0]; byte1 (i=j=2) = 0x06^0x0F = 0x09; S[2] stays 0x03.
4. Reset mid-run: assert reset for 1 cycle at cycle 100. Required: next cycle done=0, busy=0, s_wren=0, out_wren=0, all addresses 0; a following start completes normally with done after 13*MSG_LEN cycles.
5. Handshake: pulse start again during busy. Required: no effect on state or outputs. Then hold start high after done. Required: done stays 1; it falls one cycle after start=0, and IDLE is re-entered.
6. Write-enable checks, over every run: s_wren count = 2*MSG_LEN, out_wren count = MSG_LEN, never both asserted in the same cycle.
